clk_en_sched: RTL
=================

CLK_EN_SCHED -- requirements
Module: clk_en_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the issued-enable counter.
REQ-002 The block SHALL have parameter LEN_W, default 8, setting the width of the burst length.
REQ-003 The block SHALL have parameter DIV_W, default 4, setting the width of the prescaler select.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 step_req  input  1  single-cycle pulse (from a push-button one-pulser) requesting exactly one enable.
REQ-007 run_req  input  1  single-cycle pulse requesting free-run enables.
REQ-008 burst_req  input  1  single-cycle pulse requesting burst_len enables.
REQ-009 stop_req  input  1  single-cycle pulse aborting RUN or BURST.
REQ-010 burst_len  input  LEN_W  number of enables per burst, sampled with burst_req.
REQ-011 div_sel  input  DIV_W  prescaler D; run and burst enables are spaced D+1 cycles apart; sampled on RUN/BURST entry.
REQ-012 clk_en  output  1  registered, one-cycle-wide enable to the downstream datapath.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 mode  output  2  current state: 00 IDLE, 01 STEP, 10 RUN, 11 BURST.
REQ-015 en_count  output  CNT_W  total clk_en pulses issued since reset.

Function
REQ-016 The FSM SHALL have states IDLE, STEP, RUN and BURST; the timing terms below use "request in cycle N" to mean the request is sampled at the edge ending cycle N.
REQ-017 In IDLE with simultaneous requests, priority SHALL be step > burst > run, and stop_req SHALL be ignored.
REQ-018 Step timing: a step request in cycle N -> STEP in cycle N+1 with clk_en=1 in that cycle only, then IDLE in cycle N+2.
REQ-019 Run entry: a run request in cycle N -> RUN from cycle N+1 with D latched and the prescaler cleared.
REQ-020 Run output: clk_en=1 in cycles N+1+D+k(D+1) for k=0,1,2,...; with D=0, clk_en is high every cycle.
REQ-021 Burst entry: a burst request with burst_len=L≠0 -> BURST with L latched; pulse spacing is identical to RUN.
REQ-022 Burst exit: after the L-th clk_en, the state SHALL be IDLE in the following cycle.
REQ-023 A burst request with burst_len=0 SHALL be ignored, leaving the state in IDLE.
REQ-024 Stop: stop_req in cycle M during RUN or BURST -> IDLE in cycle M+1, with no clk_en in M+1 or later, including a pulse that was due in M+1.
REQ-025 In RUN and BURST, step_req, run_req and burst_req SHALL be ignored, and changes to div_sel or burst_len SHALL have no effect until the next entry.
REQ-026 In STEP, all requests SHALL be ignored.
REQ-027 en_count SHALL increment by one in each cycle where clk_en=1 and SHALL wrap from all-ones to 0.
REQ-028 busy and mode SHALL be registered and change in the same cycle as the state.
REQ-029 Prescaler and remaining-burst counters SHALL never underflow, and the remaining-burst counter SHALL be LEN_W bits wide.

Reset
REQ-030 While rst=0 (asynchronously): state=IDLE, clk_en=0, busy=0, mode=00, en_count=0, prescaler=0, burst remaining=0, latched D=0.
REQ-031 Reset asserted mid-RUN or mid-BURST SHALL drop clk_en immediately, with no completion of the burst after release.
REQ-032 After reset release, the first request SHALL be honoured on the first rising edge.

Structure
REQ-033 The state encodings, mode codes, and default CNT_W/LEN_W/DIV_W SHALL live in the shared package clk_en_sched_pkg.
REQ-034 The prescaler SHALL be a sub-module en_prescaler, with ports clk, rst, clr, d and tick, where tick asserts every d+1 cycles after clr.
REQ-035 The top level SHALL contain only the FSM, the burst counter and en_count.

Verification
REQ-036 Step: reset, then step_req in cycle 5 -> clk_en=1 only in cycle 6, mode=01 in cycle 6, en_count=1, busy=0 from cycle 7.
REQ-037 Run: run_req with div_sel=3 in cycle 0 -> clk_en in cycles 4, 8, 12, ...; stop_req in cycle 11 -> no pulse in 12, mode=00 in 12.
REQ-038 Burst: burst_req with burst_len=5 and div_sel=0 -> clk_en in cycles 1-5, IDLE in cycle 6, en_count=5; burst_len=0 -> no activity.
REQ-039 Simultaneous: step_req, run_req and burst_req in the same IDLE cycle -> STEP taken, single pulse, then IDLE.
REQ-040 Reset mid-burst: burst_len=200, rst low in cycle 50 -> all outputs reset at once, and no clk_en after release without a new request.
REQ-041 Wrap: with CNT_W=4, 17 step requests -> en_count goes 15 -> 0 -> 1.

Source files
------------

// File: rtl/clk_en_sched_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_sched_pkg
// Shared definitions for the clock-enable scheduler: default widths, FSM state
// encoding (which doubles as the externally visible mode code) and a small
// helper that identifies the states in which enables are paced by the
// prescaler.
// -----------------------------------------------------------------------------
package clk_en_sched_pkg;

    // Default parameter values for the scheduler.
    localparam int CNT_W_DEF = 16;  // issued-enable counter width
    localparam int LEN_W_DEF = 8;   // burst length width
    localparam int DIV_W_DEF = 4;   // prescaler select width

    // State encoding equals the mode code on the output port, so the state
    // register can drive the mode output directly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BURST = 2'b11
    } state_e;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_RUN   = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // RUN and BURST space their enables with the prescaler; STEP does not.
    function automatic logic is_paced(input state_e s);
        return (s == ST_RUN) || (s == ST_BURST);
    endfunction

endpackage

// File: rtl/clk_en_sched_en_prescaler.sv
// -----------------------------------------------------------------------------
// en_prescaler
// Programmable divide-by-(d+1) strobe generator used to space RUN/BURST
// enables.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   clr   in   restart: latch d and restart the count from this cycle
//   d     in   divide select D (sampled only while clr is high)
//   tick  out  look-ahead strobe: high in the cycle *before* each period
//              boundary, so the consumer can register its enable and still
//              land the pulse on the boundary. With clr in cycle N, tick is
//              high in cycles N+D, N+D+(D+1), ...; the registered pulse then
//              appears in N+1+D+k(D+1).
// -----------------------------------------------------------------------------
module en_prescaler
    import clk_en_sched_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] d,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;       // cycles left until the next boundary
    logic [DIV_W-1:0] r_d;         // latched divide select
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_d_next;

    // Down-counter reloads from the latched D at zero instead of wrapping,
    // so it never underflows.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_cnt_next = r_cnt;
        w_d_next   = r_d;
        if (clr) begin
            w_cnt_next = d;
            w_d_next   = d;
        end else if (r_cnt == '0) begin
            w_cnt_next = r_d;
        end else begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    assign tick = (w_cnt_next == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            r_cnt <= '0;
            r_d   <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_d   <= w_d_next;
        end
    end

endmodule

// File: rtl/clk_en_sched.sv
// -----------------------------------------------------------------------------
// clk_en_sched
// Clock-enable scheduler for a downstream datapath. Issues single-step,
// free-running or fixed-length bursts of one-cycle enables, with RUN/BURST
// enables spaced D+1 cycles apart by the en_prescaler sub-module.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   step_req   in   pulse: issue exactly one enable
//   run_req    in   pulse: free-run enables every D+1 cycles
//   burst_req  in   pulse: issue burst_len enables every D+1 cycles
//   stop_req   in   pulse: abort RUN or BURST
//   burst_len  in   burst length L, sampled with burst_req (0 = ignore)
//   div_sel    in   prescaler D, sampled on RUN/BURST entry
//   clk_en     out  registered one-cycle enable
//   busy       out  registered, high whenever not IDLE
//   mode       out  registered state code (00 IDLE,01 STEP,10 RUN,11 BURST)
//   en_count   out  number of clk_en pulses issued since reset (wraps)
// -----------------------------------------------------------------------------
module clk_en_sched
    import clk_en_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_req,
    input  logic             run_req,
    input  logic             burst_req,
    input  logic             stop_req,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [DIV_W-1:0] div_sel,
    output logic             clk_en,
    output logic             busy,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] en_count
);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_clk_en;
    logic             r_busy;
    logic [LEN_W-1:0] r_remain;      // enables still owed in the current burst
    logic [LEN_W-1:0] w_remain_next;
    logic [CNT_W-1:0] r_en_count;
    logic             w_clr;
    logic             w_tick;
    logic             w_en_next;

    en_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .d    (div_sel),
        .tick (w_tick)
    );

    always_comb begin
        w_state_next  = r_state;
        w_remain_next = r_remain;
        w_clr         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Priority step > burst > run; stop has nothing to abort here.
                if (step_req) begin
                    w_state_next = ST_STEP;
                end else if (burst_req && (burst_len != '0)) begin
                    w_state_next  = ST_BURST;
                    w_remain_next = burst_len;
                    w_clr         = 1'b1;
                end else if (run_req) begin
                    w_state_next = ST_RUN;
                    w_clr        = 1'b1;
                end
            end

            ST_STEP: begin
                w_state_next = ST_IDLE;
            end

            ST_RUN: begin
                if (stop_req) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_BURST: begin
                if (stop_req) begin
                    w_state_next  = ST_IDLE;
                    w_remain_next = '0;
                end else if (r_clk_en) begin
                    // The pulse being issued now is the last one owed: leave
                    // next cycle. The <= 1 compare keeps the counter from
                    // ever wrapping below zero.
                    if (r_remain <= LEN_W'(1)) begin
                        w_state_next  = ST_IDLE;
                        w_remain_next = '0;
                    end else begin
                        w_remain_next = r_remain - 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // clk_en is decided from the *next* state, so a stop or burst end
        // suppresses a pulse that the prescaler would have produced.
        w_en_next = (w_state_next == ST_STEP) ||
                    (is_paced(w_state_next) && w_tick);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_clk_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_remain   <= '0;
            r_en_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_clk_en <= w_en_next;
            r_busy   <= (w_state_next != ST_IDLE);
            r_remain <= w_remain_next;
            if (r_clk_en) begin
                r_en_count <= r_en_count + 1'b1;
            end
        end
    end

    assign clk_en   = r_clk_en;
    assign busy     = r_busy;
    assign mode     = r_state;
    assign en_count = r_en_count;

endmodule
